// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 binary32 divider: 26-step radix-2 restoring mantissa divide,
// DAZ on inputs, FTZ on results, five rounding modes and a valid/ready handshake.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        dbz
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        x_q, x_d, y_q, y_d, z_q, z_d;
  logic [2:0]         rm_q, rm_d, flags_q, flags_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        div_q, div_d;
  logic [25:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;

  // operand classification (denormals count as zero)
  logic x_max, y_max, x_zero, y_zero, x_nan, y_nan, x_inf, y_inf, sgn;
  logic [31:0] spec_z;
  logic        spec_dbz;

  // rounding datapath
  logic               norm, guard, sticky, inc, carry, to_inf;
  logic [22:0]        frac, mant;
  logic signed [9:0]  exp_n, exp_r;
  logic [31:0]        rnd_z;
  logic [2:0]         rnd_flags;
  logic [23:0]        diff;

  assign x_max  = &x_q[30:23];
  assign y_max  = &y_q[30:23];
  assign x_zero = ~|x_q[30:23];
  assign y_zero = ~|y_q[30:23];
  assign x_nan  = x_max & (|x_q[22:0]);
  assign y_nan  = y_max & (|y_q[22:0]);
  assign x_inf  = x_max & ~(|x_q[22:0]);
  assign y_inf  = y_max & ~(|y_q[22:0]);
  assign sgn    = x_q[31] ^ y_q[31];
  assign diff   = rem_q[23:0] - div_q;

  always_comb begin
    spec_dbz = 1'b0;
    if (x_nan | y_nan | (x_inf & y_inf) | (x_zero & y_zero)) spec_z = 32'h7FC0_0000;
    else if (x_inf)                                         spec_z = {sgn, 8'hFF, 23'd0};
    else if (y_zero) begin
      spec_z   = {sgn, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end
    else                                                    spec_z = {sgn, 31'd0};
  end

  // The quotient is 1.x when its top bit is set, otherwise 0.1x and needs one left shift.
  always_comb begin
    norm   = quo_q[25];
    frac   = norm ? quo_q[24:2] : quo_q[23:1];
    guard  = norm ? quo_q[1] : quo_q[0];
    sticky = (norm & quo_q[0]) | (|rem_q);
    exp_n  = norm ? exp_q : exp_q - 10'sd1;
    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = ~sign_q & (guard | sticky);
      3'd3:    inc = sign_q & (guard | sticky);
      3'd4:    inc = guard;
      default: inc = guard & (sticky | frac[0]);
    endcase
    {carry, mant} = {1'b0, frac} + {23'd0, inc};
    exp_r  = carry ? exp_n + 10'sd1 : exp_n;
    case (rm_q)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = ~sign_q;
      3'd3:    to_inf = sign_q;
      default: to_inf = 1'b1;
    endcase
    rnd_flags = 3'b000;
    if (exp_r >= 10'sd255) begin
      rnd_flags = 3'b100;
      rnd_z     = to_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 8'hFE, 23'h7F_FFFF};
    end else if (exp_r <= 10'sd0) begin
      rnd_flags = 3'b010;
      rnd_z     = {sign_q, 31'd0};
    end else begin
      rnd_z     = {sign_q, exp_r[7:0], mant};
    end
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rm_d    = rm_q;
    z_d     = z_q;
    flags_d = flags_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d     = fp_X;
        y_d     = fp_Y;
        rm_d    = r_mode;
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d = sgn;
        exp_d  = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
        rem_d  = {2'b01, x_q[22:0]};
        div_d  = {1'b1, y_q[22:0]};
        quo_d  = '0;
        cnt_d  = '0;
        if (x_max | y_max | x_zero | y_zero) begin
          z_d     = spec_z;
          flags_d = {2'b00, spec_dbz};
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (rem_q >= {1'b0, div_q}) begin
          quo_d = {quo_q[24:0], 1'b1};
          rem_d = {diff, 1'b0};
        end else begin
          quo_d = {quo_q[24:0], 1'b0};
          rem_d = {rem_q[23:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) state_d = ROUND;
      end
      ROUND: begin
        z_d     = rnd_z;
        flags_d = rnd_flags;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  // NOTE: datapath registers are not reset; they are always loaded before they are read.
  always_ff @(posedge clk) begin
    x_q    <= x_d;
    y_q    <= y_d;
    rm_q   <= rm_d;
    sign_q <= sign_d;
    exp_q  <= exp_d;
    rem_q  <= rem_d;
    div_q  <= div_d;
    quo_q  <= quo_d;
    cnt_q  <= cnt_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign fp_Z      = z_q;
  assign ovrf      = out_valid & flags_q[2];
  assign udrf      = out_valid & flags_q[1];
  assign dbz       = out_valid & flags_q[0];

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed vectors push expectations, a negedge
// monitor pops and compares result, flags and latency whenever out_valid is seen.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] fp_X = '0, fp_Y = '0;
  logic [2:0]  r_mode = '0;
  logic        in_ready, out_valid, ovrf, udrf, dbz;
  logic [31:0] fp_Z;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
    .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .dbz(dbz)
  );

  typedef struct {
    logic [31:0] z;
    logic [2:0]  fl;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic [2:0]  fl;   // {ovrf, udrf, dbz}
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass = 0, n_total = 0, cyc = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) begin
        seen = 1'b0;
        check("flags_while_invalid", {29'd0, ovrf, udrf, dbz}, 32'd0);
      end else if (sb_q.size() == 0) begin
        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc + 1 - sb_q[0].t0), 32'(sb_q[0].lat));
        end
        check("fp_Z", fp_Z, sb_q[0].z);
        check("flags", {29'd0, ovrf, udrf, dbz}, {29'd0, sb_q[0].fl});
        if (out_ready) begin
          void'(sb_q.pop_front());
          seen = 1'b0;
        end else begin
          check("in_ready_stalled", {31'd0, in_ready}, 32'd0);
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                      input logic [31:0] z, input logic [2:0] fl, input int lat,
                      input bit expect_result);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    fp_X     = x;
    fp_Y     = y;
    r_mode   = rm;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout("in_ready_wait");
      in_valid = 1'b0;
      return;
    end
    if (expect_result) sb_q.push_back('{z, fl, lat, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      timeout("drain");
      sb_q.delete();
    end
  endtask

  vec_t vecs[] = '{
    '{32'h40400000, 32'h40000000, 3'd0, 32'h3FC00000, 3'b000, 29},
    '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 3'b000, 29},
    '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 3'b000, 29},
    '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 3'b000, 29},
    '{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 3'b000, 29},
    '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAA, 3'b000, 29},
    '{32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAB, 3'b000, 29},
    '{32'hC0C00000, 32'hC0000000, 3'd0, 32'h40400000, 3'b000, 29},
    '{32'h3FFFFFFE, 32'h3FFFFFFF, 3'd1, 32'h3F7FFFFE, 3'b000, 29},
    '{32'h3FFFFFFE, 32'h3FFFFFFF, 3'd0, 32'h3F7FFFFF, 3'b000, 29},
    '{32'h7F7FFFFF, 32'h00800000, 3'd0, 32'h7F800000, 3'b100, 29},
    '{32'h7F7FFFFF, 32'h00800000, 3'd1, 32'h7F7FFFFF, 3'b100, 29},
    '{32'h7F7FFFFF, 32'h00800000, 3'd2, 32'h7F800000, 3'b100, 29},
    '{32'h7F7FFFFF, 32'h00800000, 3'd3, 32'h7F7FFFFF, 3'b100, 29},
    '{32'hFF7FFFFF, 32'h00800000, 3'd2, 32'hFF7FFFFF, 3'b100, 29},
    '{32'h7F000000, 32'h3F000000, 3'd0, 32'h7F800000, 3'b100, 29},
    '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 3'b010, 29},
    '{32'h80800000, 32'h40000000, 3'd0, 32'h80000000, 3'b010, 29},
    '{32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 3'b000, 29},
    '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 3'b001, 2},
    '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 3'b000, 2},
    '{32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, 3'b000, 2},
    '{32'hBF800000, 32'h00000001, 3'd0, 32'hFF800000, 3'b001, 2},
    '{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 3'b000, 2},
    '{32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 3'b000, 2},
    '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 3'b000, 2},
    '{32'hC0000000, 32'h7F800000, 3'd0, 32'h80000000, 3'b000, 2}
  };

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_fp_Z", fp_Z, 32'd0);
    check("reset_flags", {29'd0, ovrf, udrf, dbz}, 32'd0);

    foreach (vecs[i])
      send(vecs[i].x, vecs[i].y, vecs[i].rm, vecs[i].z, vecs[i].fl, vecs[i].lat, 1'b1);
    drain();

    // Consumer stall: result must hold while out_ready is low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h40400000, 32'h40000000, 3'd0, 32'h3FC00000, 3'b000, 29, 1'b1);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("stall_wait_valid");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset during DIV: operation is discarded, nothing is emitted.
    send(32'h3F800000, 32'h40400000, 3'd0, 32'h0, 3'b000, 0, 1'b0);
    repeat (12) @(negedge clk);
    check("busy_before_reset", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    send(32'hC0400000, 32'h40000000, 3'd0, 32'hBFC00000, 3'b000, 29, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have no parameters; format fixed to IEEE-754 binary32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 fp_X  input  32  dividend.
REQ-007 fp_Y  input  32  divisor.
REQ-008 r_mode  input  3  rounding: 0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf, 4 RMM, 5-7 treated as RNE.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 fp_Z  output  32  quotient fp_X/fp_Y.
REQ-012 ovrf  output  1  overflow flag, valid with out_valid.
REQ-013 udrf  output  1  underflow flag, valid with out_valid.
REQ-014 dbz  output  1  divide-by-zero flag (finite nonzero / zero), valid with out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, UNPACK, DIV, ROUND, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; transfer when in_valid & in_ready; fp_X, fp_Y, r_mode captured on that edge.
REQ-017 IDLE->UNPACK on transfer; UNPACK->DONE for special operands; UNPACK->DIV otherwise.
REQ-018 DIV SHALL run exactly 26 radix-2 restoring iterations (one per cycle), then ->ROUND; ROUND->DONE after one cycle.
REQ-019 Latency: out_valid first high 29 cycles after transfer edge for normal/denormal operands, 2 cycles for special operands; fixed, data-independent.
REQ-020 DONE: out_valid=1; fp_Z and flags held stable while out_ready=0; DONE->IDLE on out_valid & out_ready; no new transfer in the same cycle.
REQ-021 Denormal inputs SHALL be treated as signed zero (DAZ).
REQ-022 Sign of fp_Z = sign(fp_X) XOR sign(fp_Y) for all non-NaN results.
REQ-023 Exponent: 10-bit signed datapath, biased result = eX - eY + 127, decremented by 1 when mantissa quotient < 1.0 (normalize by one left shift).
REQ-024 Quotient: 24 significant bits plus guard bit; sticky = OR of final remainder; rounding per r_mode on these.
REQ-025 Rounding carry-out SHALL increment exponent and reset mantissa to 1.0.
REQ-026 Overflow (biased exp >= 255 after rounding): ovrf=1; fp_Z = +/-inf for RNE/RMM and for +inf/-inf modes rounding away from zero; else +/-0x7F7FFFFF magnitude.
REQ-027 Underflow (biased exp <= 0 after rounding): udrf=1; fp_Z = signed zero (FTZ).
REQ-028 Specials: any NaN input, 0/0, inf/inf -> 0x7FC00000, flags 0; inf/finite or finite-nonzero/0 -> signed inf (dbz=1 only for /0); 0/x or finite/inf -> signed zero, flags 0.
REQ-029 Flags SHALL be 0 whenever out_valid=0.
REQ-030 Result SHALL be bit-identical for all in_valid timings and out_ready stall patterns.

Reset
REQ-031 rst=1 SHALL force IDLE at next edge from any state, including mid-DIV; in-flight operation discarded, no result emitted.
REQ-032 Reset values: out_valid=0, fp_Z=0x00000000, ovrf=0, udrf=0, dbz=0, in_ready=1 after reset release.
REQ-033 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-034 0x40400000 / 0x40000000, r_mode=0 -> fp_Z=0x3FC00000, flags 0, out_valid at transfer+29.
REQ-035 0x3F800000 / 0x40400000: r_mode=0 -> 0x3EAAAAAB; r_mode=1 -> 0x3EAAAAAA.
REQ-036 0x7F7FFFFF / 0x00800000: r_mode=0 -> 0x7F800000 ovrf=1; r_mode=1 -> 0x7F7FFFFF ovrf=1.
REQ-037 0x3F800000 / 0x00000000 -> 0x7F800000 dbz=1 at transfer+2; 0x00000000 / 0x00000000 -> 0x7FC00000 dbz=0.
REQ-038 Hold out_ready=0 for 10 cycles in DONE -> fp_Z stable, in_ready=0; then rst asserted during cycle 12 of DIV on next op -> out_valid=0, in_ready=1 after one edge.
REQ-039 Formal: two instances, X/Y swapped with sign-adjusted reciprocal relations SHALL NOT be used; instead check DUT against a*b/b round-trip only for exact quotients (powers of two).
